// File: rtl/rgb2yuv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb2yuv_ctrl_if
// Brief    : Pixel-in / YUV-out handshake and coefficient ROM port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface rgb2yuv_ctrl_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  r_in;
  logic [PIX_W-1:0]  g_in;
  logic [PIX_W-1:0]  b_in;
  logic [2:0]        rom_addr;
  logic [COEF_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  y_out;
  logic [PIX_W-1:0]  u_out;
  logic [PIX_W-1:0]  v_out;

  // master = pixel source, YUV sink and ROM together
  modport master (
    output in_valid, r_in, g_in, b_in, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, y_out, u_out, v_out
  );

  modport slave (
    input  in_valid, r_in, g_in, b_in, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, y_out, u_out, v_out
  );
endinterface
`default_nettype wire

// File: rtl/rgb2yuv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgb2yuv_ctrl
// Brief    : Time-multiplexed RGB->YUV MAC sequencer driving an external ROM.
// Revision : 1.0 - initial release
// ============================================================================
module rgb2yuv_ctrl #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 9,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 19
) (
  input  logic          clk,
  input  logic          rst,
  rgb2yuv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] c_rnd = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] c_ofs = ACC_W'(2 ** (PIX_W - 1));
  localparam logic signed [ACC_W-1:0] c_max = ACC_W'(2 ** PIX_W - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_step;
  logic signed [ACC_W-1:0] r_acc;
  logic [PIX_W-1:0]        r_r, r_g, r_b;
  logic [PIX_W-1:0]        r_y, r_u, r_v;

  logic [2:0]              w_addr;
  logic [PIX_W-1:0]        w_pix;
  logic                    w_first;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_coef;
  logic signed [ACC_W-1:0] w_pixs;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_ch;
  logic signed [ACC_W-1:0] w_off;
  logic [PIX_W-1:0]        w_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)   w_state_nxt = MAC;
      MAC:     if (r_step == 4'd8) w_state_nxt = HOLD;
      HOLD:    if (bus.out_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Schedule: R,G,B for Y (ROM 0,1,7), then U (2,3,4), then V (4,5,6)
  always_comb begin
    w_addr  = 3'd0;
    w_pix   = r_r;
    w_first = 1'b0;
    w_last  = 1'b0;
    if (r_state == MAC) begin
      case (r_step)
        4'd0:    begin w_addr = 3'd0; w_pix = r_r; w_first = 1'b1; end
        4'd1:    begin w_addr = 3'd1; w_pix = r_g; end
        4'd2:    begin w_addr = 3'd7; w_pix = r_b; w_last  = 1'b1; end
        4'd3:    begin w_addr = 3'd2; w_pix = r_r; w_first = 1'b1; end
        4'd4:    begin w_addr = 3'd3; w_pix = r_g; end
        4'd5:    begin w_addr = 3'd4; w_pix = r_b; w_last  = 1'b1; end
        4'd6:    begin w_addr = 3'd4; w_pix = r_r; w_first = 1'b1; end
        4'd7:    begin w_addr = 3'd5; w_pix = r_g; end
        4'd8:    begin w_addr = 3'd6; w_pix = r_b; w_last  = 1'b1; end
        default: begin w_addr = 3'd0; w_pix = r_r; end
      endcase
    end
  end

  assign w_coef = $signed({{(ACC_W-COEF_W){bus.rom_data[COEF_W-1]}}, bus.rom_data});
  assign w_pixs = $signed({{(ACC_W-PIX_W){1'b0}}, w_pix});
  assign w_prod = w_coef * w_pixs;

  always_comb begin
    w_base = r_acc;
    if (w_first) w_base = '0;
  end

  assign w_sum = w_base + w_prod;
  assign w_ch  = (w_sum + c_rnd) >>> FRAC;

  // Chroma results are re-centred on mid-scale before clamping
  always_comb begin
    w_off = w_ch;
    if (r_step != 4'd2) w_off = w_ch + c_ofs;
  end

  always_comb begin
    w_sat = w_off[PIX_W-1:0];
    if (w_off[ACC_W-1])     w_sat = '0;
    else if (w_off > c_max) w_sat = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= 4'd0;
      r_acc  <= '0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_y    <= '0;
      r_u    <= '0;
      r_v    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_r    <= bus.r_in;
            r_g    <= bus.g_in;
            r_b    <= bus.b_in;
            r_step <= 4'd0;
          end
        end
        MAC: begin
          r_step <= r_step + 4'd1;
          r_acc  <= w_sum;
          if (w_last) begin
            case (r_step)
              4'd2:    r_y <= w_sat;
              4'd5:    r_u <= w_sat;
              default: r_v <= w_sat;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.rom_addr  = w_addr;
  assign bus.y_out     = r_y;
  assign bus.u_out     = r_u;
  assign bus.v_out     = r_v;

endmodule
`default_nettype wire
